// File: rtl/uart_rx_ext_if.sv
// Host-side read bus of the UART receiver: FIFO head, occupancy and status flags.
// The receiver owns the slave modport; the host reading characters owns the master modport.
interface uart_rx_ext_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_ferr;
  logic [CW-1:0]        fifo_cnt;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 break_det;

  modport slave (
    input  rd_en, clr_overrun,
    output rd_valid, rd_data, rd_perr, rd_ferr, fifo_cnt, overrun, break_det
  );

  modport master (
    output rd_en, clr_overrun,
    input  rd_valid, rd_data, rd_perr, rd_ferr, fifo_cnt, overrun, break_det
  );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: bit-centre sampling FSM feeding a first-word-fall-through FIFO
// that stores each character together with its parity and framing error flags.
module uart_rx_ext #(
  parameter int BAUD_DIV   = 87,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rxd,
  uart_rx_ext_if.slave  host
);
  localparam int HALF  = BAUD_DIV / 2;
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nx;
  logic                 rxd_p0, rxd_p1, rxd_p2;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 sample, cnt_clr, shift_en, par_en, stop_en, push;
  logic                 perr_fin, ferr_fin, is_break;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, pop, wr_acc, overrun_q;
  logic [EW-1:0]        head;

  function automatic logic calc_perr(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 0)      return 1'b0;
    else if (PARITY == 1) return ~(^d ^ p);
    else                  return ^d ^ p;
  endfunction

  // Stage p0/p1: metastability synchroniser; p2: previous value for falling-edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign sample = (cnt == CNT_W'(HALF));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE:  if (rxd_p2 && !rxd_p1) begin
               cnt_clr  = 1'b1;
               state_nx = START;
             end
      START: if (sample) state_nx = rxd_p1 ? IDLE : DATA;
      DATA:  if (sample) begin
               shift_en = 1'b1;
               if (bit_idx == BIT_W'(DATA_BITS - 1)) state_nx = (PARITY != 0) ? PAR : STOP;
             end
      PAR:   if (sample) begin
               par_en   = 1'b1;
               state_nx = STOP;
             end
      STOP:  if (sample) begin
               stop_en = 1'b1;
               if (stop_idx == 1'(STOP_BITS - 1)) begin
                 push     = 1'b1;
                 state_nx = IDLE;
               end
             end
      default: state_nx = IDLE;
    endcase
  end

  // Counter free-runs so every sample after the start sample is exactly one bit period apart
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (cnt_clr || cnt == CNT_W'(BAUD_DIV - 1)) cnt <= '0;
      else                                        cnt <= cnt + CNT_W'(1);
      if (cnt_clr) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else begin
        if (shift_en) bit_idx  <= bit_idx + BIT_W'(1);
        if (stop_en)  stop_idx <= stop_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg   <= {rxd_p1, shreg[DATA_BITS-1:1]};
    if (par_en)   par_bit <= rxd_p1;
    if (cnt_clr)                  ferr_acc <= 1'b0;
    else if (stop_en && !rxd_p1)  ferr_acc <= 1'b1;
  end

  // The final stop sample is folded in combinationally because the push happens in that cycle
  assign ferr_fin  = ferr_acc | ~rxd_p1;
  assign perr_fin  = calc_perr(shreg, par_bit);
  assign is_break  = (shreg == '0) && ((PARITY == 0) || !par_bit) && ferr_fin;
  assign host.break_det = push && is_break;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = host.rd_en && (count != '0);
  assign wr_acc = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= {shreg, perr_fin, ferr_fin};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overrun_q <= 1'b1;
      else if (host.clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign host.rd_valid = (count != '0);
  assign host.rd_data  = host.rd_valid ? head[EW-1:2] : '0;
  assign host.rd_perr  = host.rd_valid ? head[1] : 1'b0;
  assign host.rd_ferr  = host.rd_valid ? head[0] : 1'b0;
  assign host.fifo_cnt = count;
  assign host.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8E1 instance and a 7O2 instance, both at 16 clocks per bit.
module tb_uart_rx_ext;
  localparam int BD = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rxd8 = 1'b1;
  logic rxd7 = 1'b1;

  always #5 clk = ~clk;

  uart_rx_ext_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus8 ();
  uart_rx_ext_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus7 ();

  uart_rx_ext #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rstn(rstn), .rxd(rxd8), .host(bus8.slave)
  );
  uart_rx_ext #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rstn(rstn), .rxd(rxd7), .host(bus7.slave)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  int   brk_cnt = 0;
  logic vld_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vld_q <= bus8.rd_valid;
    if (bus8.rd_valid && !vld_q) rise_cyc <= cyc;
    if (bus8.break_det) brk_cnt <= brk_cnt + 1;
  end

  function automatic logic [15:0] f8(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  // Caller is on a falling edge; each bit is held for one bit period, line returns high after.
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd8 = bits[i];
      else          rxd7 = bits[i];
      repeat (BD) @(negedge clk);
    end
    rxd8 = 1'b1;
    rxd7 = 1'b1;
  endtask

  task automatic pop8();
    bus8.rd_en = 1'b1;
    @(negedge clk);
    bus8.rd_en = 1'b0;
  endtask

  task automatic pop7();
    bus7.rd_en = 1'b1;
    @(negedge clk);
    bus7.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b, expected 0", bus8.rd_valid); end
    n_chk++; if (bus8.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %0h, expected 0", bus8.rd_data); end
    n_chk++; if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_cnt: got %0d, expected 0", bus8.fifo_cnt); end
    n_chk++; if (bus8.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b, expected 0", bus8.overrun); end
    n_chk++; if (bus8.break_det !== 1'b0) begin n_fail++; $display("FAIL reset_break_det: got %0b, expected 0", bus8.break_det); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    send(0, f8(8'h5B, 1'b1), 11);
    repeat (4) @(negedge clk);
    // Stop sample lands 171 clocks after the start bit is driven; rd_valid follows one edge later
    n_chk++; if (rise_cyc - start_cyc !== 172) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 172", rise_cyc - start_cyc); end
    n_chk++; if (bus8.rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b, expected 1", bus8.rd_valid); end
    n_chk++; if (bus8.rd_data !== 8'h5B) begin n_fail++; $display("FAIL basic_data: got %0h, expected 5b", bus8.rd_data); end
    n_chk++; if (bus8.rd_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %0b, expected 0", bus8.rd_perr); end
    n_chk++; if (bus8.rd_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %0b, expected 0", bus8.rd_ferr); end
    n_chk++; if (bus8.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d, expected 1", bus8.fifo_cnt); end
    pop8();
  endtask

  task automatic test_parity_err();
    send(0, f8(8'h5B, 1'b0), 11);
    repeat (4) @(negedge clk);
    n_chk++; if (bus8.rd_data !== 8'h5B) begin n_fail++; $display("FAIL perr_data: got %0h, expected 5b", bus8.rd_data); end
    n_chk++; if (bus8.rd_perr !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %0b, expected 1", bus8.rd_perr); end
    n_chk++; if (bus8.rd_ferr !== 1'b0) begin n_fail++; $display("FAIL perr_ferr: got %0b, expected 0", bus8.rd_ferr); end
    pop8();
    n_chk++; if (bus8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL perr_empty_valid: got %0b, expected 0", bus8.rd_valid); end
    n_chk++; if (bus8.rd_perr !== 1'b0) begin n_fail++; $display("FAIL perr_empty_flag: got %0b, expected 0", bus8.rd_perr); end
  endtask

  task automatic test_7o2();
    // start, 7 data bits of 0x41, odd parity 1, first stop 1, second stop 0
    send(1, {5'b0, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
    repeat (4) @(negedge clk);
    n_chk++; if (bus7.rd_data !== 7'h41) begin n_fail++; $display("FAIL o2_data: got %0h, expected 41", bus7.rd_data); end
    n_chk++; if (bus7.rd_perr !== 1'b0) begin n_fail++; $display("FAIL o2_perr: got %0b, expected 0", bus7.rd_perr); end
    n_chk++; if (bus7.rd_ferr !== 1'b1) begin n_fail++; $display("FAIL o2_ferr: got %0b, expected 1", bus7.rd_ferr); end
    n_chk++; if (bus7.break_det !== 1'b0) begin n_fail++; $display("FAIL o2_break: got %0b, expected 0", bus7.break_det); end
    pop7();
  endtask

  task automatic test_break();
    int b0;
    b0 = brk_cnt;
    rxd8 = 1'b0;
    repeat (3 * 11 * BD) @(negedge clk);
    rxd8 = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++; if (bus8.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL break_cnt: got %0d, expected 1", bus8.fifo_cnt); end
    n_chk++; if (bus8.rd_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %0h, expected 0", bus8.rd_data); end
    n_chk++; if (bus8.rd_ferr !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %0b, expected 1", bus8.rd_ferr); end
    n_chk++; if (bus8.rd_perr !== 1'b0) begin n_fail++; $display("FAIL break_perr: got %0b, expected 0", bus8.rd_perr); end
    n_chk++; if (brk_cnt - b0 !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d, expected 1", brk_cnt - b0); end
    pop8();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send(0, f8(d, ^d), 11);
    end
    repeat (4) @(negedge clk);
    n_chk++; if (bus8.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovr_cnt: got %0d, expected 4", bus8.fifo_cnt); end
    n_chk++; if (bus8.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b, expected 1", bus8.overrun); end
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      n_chk++; if (bus8.rd_data !== d) begin n_fail++; $display("FAIL ovr_pop%0d: got %0h, expected %0h", i, bus8.rd_data, d); end
      pop8();
    end
    n_chk++; if (bus8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty_valid: got %0b, expected 0", bus8.rd_valid); end
    n_chk++; if (bus8.rd_data !== 8'h00) begin n_fail++; $display("FAIL ovr_empty_data: got %0h, expected 0", bus8.rd_data); end
    n_chk++; if (bus8.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b, expected 1", bus8.overrun); end
    pop8();
    n_chk++; if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL ovr_pop_empty: got %0d, expected 0", bus8.fifo_cnt); end
    bus8.clr_overrun = 1'b1;
    @(negedge clk);
    bus8.clr_overrun = 1'b0;
    n_chk++; if (bus8.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b, expected 0", bus8.overrun); end
  endtask

  task automatic test_glitch();
    rxd8 = 1'b0;
    repeat (4) @(negedge clk);
    rxd8 = 1'b1;
    repeat (12 * BD) @(negedge clk);
    n_chk++; if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL glitch_cnt: got %0d, expected 0", bus8.fifo_cnt); end
    n_chk++; if (bus8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %0b, expected 0", bus8.rd_valid); end
  endtask

  task automatic test_reset_mid();
    send(0, f8(8'h5B, 1'b1), 11);
    rxd8 = 1'b0;
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (bus8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b, expected 0", bus8.rd_valid); end
    n_chk++; if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d, expected 0", bus8.fifo_cnt); end
    n_chk++; if (bus8.rd_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %0h, expected 0", bus8.rd_data); end
    rxd8 = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    send(0, f8(8'hA5, 1'b0), 11);
    repeat (4) @(negedge clk);
    n_chk++; if (bus8.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL rmid_after_cnt: got %0d, expected 1", bus8.fifo_cnt); end
    n_chk++; if (bus8.rd_data !== 8'hA5) begin n_fail++; $display("FAIL rmid_after_data: got %0h, expected a5", bus8.rd_data); end
    n_chk++; if (bus8.rd_perr !== 1'b0 || bus8.rd_ferr !== 1'b0) begin n_fail++; $display("FAIL rmid_after_flags: got %0b%0b, expected 00", bus8.rd_perr, bus8.rd_ferr); end
    pop8();
  endtask

  initial begin
    bus8.rd_en = 1'b0;
    bus8.clr_overrun = 1'b0;
    bus7.rd_en = 1'b0;
    bus7.clr_overrun = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity_err();
    test_7o2();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
